layer_merge: RTL and testbench



---
 rtl/gpu_mem_pkg.sv | 30 +++
 rtl/layer_merge_row.sv | 36 +++
 rtl/layer_merge.sv | 113 +++++++++++
 tb/tb_layer_merge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared SRAM map, row geometry and pixel type for the GPU memory initiators.
// Also holds the layer_merge FSM state encoding.
package gpu_mem_pkg;

    localparam int unsigned L1_BASE   = 0;
    localparam int unsigned L2_BASE   = 65536;
    localparam int unsigned TEX1_BASE = 131072;
    localparam int unsigned TEX2_BASE = 135168;
    localparam int unsigned TEX3_BASE = 139264;
    localparam int unsigned OUT_BASE  = 143360;

    localparam int unsigned ROW_WORDS        = 64;
    localparam int unsigned LAYER_ROW_STRIDE = 256;

    typedef logic [23:0] pixel_t;

    typedef enum logic [3:0] {
        IDLE,
        RD1_A,
        RD1_B,
        CAP1,
        RD2_A,
        RD2_B,
        CAP2,
        MERGE,
        WR,
        DONE
    } merge_state_t;

endpackage

// File: rtl/layer_merge_row.sv
// Combinational per-lane key select of layer2 over layer1.
// With LAYER_MERGE_BG_EN, lanes transparent in both layers take bg_color.
module merge_row
    import gpu_mem_pkg::*;
#(
    parameter int unsigned LANES = ROW_WORDS
) (
    input  logic [LANES*24-1:0] l1_row,
    input  logic [LANES*24-1:0] l2_row,
    input  pixel_t              key_color,
`ifdef LAYER_MERGE_BG_EN
    input  pixel_t              bg_color,
`endif
    output logic [LANES*24-1:0] out_row
);

    always_comb begin
        pixel_t a;
        pixel_t b;
        out_row = '0;
        for (int unsigned p = 0; p < LANES; p++) begin
            a = l1_row[p*24 +: 24];
            b = l2_row[p*24 +: 24];
            if (b != key_color) begin
                out_row[p*24 +: 24] = b;
            end else begin
`ifdef LAYER_MERGE_BG_EN
                out_row[p*24 +: 24] = (a == key_color) ? bg_color : a;
`else
                out_row[p*24 +: 24] = a;
`endif
            end
        end
    end

endmodule

// File: rtl/layer_merge.sv
// Composites layer1/layer2 into the output buffer, one 64-word chunk at a time.
// Optional macro LAYER_MERGE_BG_EN adds bg_color for pixels transparent in both layers.
module layer_merge
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_SIZE_BITS  = 24,
    parameter int unsigned WORD_SIZE_BYTES = 3,
    parameter int unsigned DATA_SIZE_WORDS = 64,
    parameter int unsigned L1_BASE         = gpu_mem_pkg::L1_BASE,
    parameter int unsigned L2_BASE         = gpu_mem_pkg::L2_BASE,
    parameter int unsigned OUT_BASE        = gpu_mem_pkg::OUT_BASE,
    parameter int unsigned NUM_CHUNKS      = 1024
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        merge_en,
    output logic                                        merge_done,
    input  logic [23:0]                                 key_color,
`ifdef LAYER_MERGE_BG_EN
    input  logic [23:0]                                 bg_color,
`endif
    output logic                                        read_enable,
    output logic                                        write_enable,
    input  logic [DATA_SIZE_WORDS*WORD_SIZE_BYTES*8-1:0] read_data,
    output logic [DATA_SIZE_WORDS*WORD_SIZE_BYTES*8-1:0] write_data,
    output logic [ADDR_SIZE_BITS-1:0]                   address
);

    localparam int unsigned ROW_BITS = DATA_SIZE_WORDS * WORD_SIZE_BYTES * 8;
    localparam int unsigned CW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    merge_state_t  state, state_nxt;
    logic [CW-1:0] chunk, chunk_nxt;
    logic [ROW_BITS-1:0] l1_row, l2_row, merged;

    function automatic logic [ADDR_SIZE_BITS-1:0] row_addr(input int unsigned base,
                                                           input logic [CW-1:0] c);
        return ADDR_SIZE_BITS'(base)
             + ADDR_SIZE_BITS'(c) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
    endfunction

    merge_row #(.LANES(DATA_SIZE_WORDS)) u_merge_row (
        .l1_row   (l1_row),
        .l2_row   (l2_row),
        .key_color(key_color),
`ifdef LAYER_MERGE_BG_EN
        .bg_color (bg_color),
`endif
        .out_row  (merged)
    );

    always_comb begin
        state_nxt = state;
        chunk_nxt = chunk;
        unique case (state)
            IDLE: begin
                if (merge_en) begin
                    state_nxt = RD1_A;
                    chunk_nxt = '0;
                end
            end
            RD1_A: state_nxt = RD1_B;
            RD1_B: state_nxt = CAP1;
            CAP1:  state_nxt = RD2_A;
            RD2_A: state_nxt = RD2_B;
            RD2_B: state_nxt = CAP2;
            CAP2:  state_nxt = MERGE;
            MERGE: state_nxt = WR;
            WR: begin
                if (chunk == CW'(NUM_CHUNKS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD1_A;
                    chunk_nxt = chunk + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and address are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state        <= IDLE;
            chunk        <= '0;
            l1_row       <= '0;
            l2_row       <= '0;
            merge_done   <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
        end else begin
            state        <= state_nxt;
            chunk        <= chunk_nxt;
            merge_done   <= (state_nxt == DONE);
            read_enable  <= (state_nxt == RD1_A) || (state_nxt == RD1_B) ||
                            (state_nxt == RD2_A) || (state_nxt == RD2_B);
            write_enable <= (state_nxt == WR);
            unique case (state_nxt)
                RD1_A, RD1_B: address <= row_addr(L1_BASE, chunk_nxt);
                RD2_A, RD2_B: address <= row_addr(L2_BASE, chunk_nxt);
                WR:           address <= row_addr(OUT_BASE, chunk_nxt);
                default:      address <= '0;
            endcase
            if (state == CAP1)  l1_row     <= read_data;
            if (state == CAP2)  l2_row     <= read_data;
            if (state == MERGE) write_data <= merged;
        end
    end

endmodule

// File: tb/tb_layer_merge.sv
// Directed bench for layer_merge with a behavioural SRAM; honours LAYER_MERGE_BG_EN.
module tb_layer_merge;

    localparam int unsigned NC   = 1024;
    localparam int unsigned L2B  = 65536;
    localparam int unsigned OUTB = 143360;
    localparam logic [23:0] KEY  = 24'hFF00FF;
`ifdef LAYER_MERGE_BG_EN
    localparam logic [23:0] BOTH_KEY_EXP = 24'h101010;
`else
    localparam logic [23:0] BOTH_KEY_EXP = KEY;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          merge_en;
    logic          merge_done;
    logic [23:0]   key_color;
    logic [23:0]   bg_color;
    logic          read_enable;
    logic          write_enable;
    logic [1535:0] read_data = '0;
    logic [1535:0] write_data;
    logic [23:0]   address;

    layer_merge dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .merge_en    (merge_en),
        .merge_done  (merge_done),
        .key_color   (key_color),
`ifdef LAYER_MERGE_BG_EN
        .bg_color    (bg_color),
`endif
        .read_enable (read_enable),
        .write_enable(write_enable),
        .read_data   (read_data),
        .write_data  (write_data),
        .address     (address)
    );

    always #5 clk = ~clk;

    logic [23:0] l1_mem  [0:65535];
    logic [23:0] l2_mem  [0:65535];
    logic [23:0] out_mem [0:65535];

    int unsigned cyc = 0;
    int unsigned n_checks = 0, n_fail = 0;
    int unsigned wr_count, first_wr, last_wr, done_count, done_cyc;
    int unsigned run, prev_addr, h320, h65856, first_rd_addr;
    bit          prev_re, hit_143552, first_rd_valid;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model and bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (read_enable) begin
            run = (prev_re && address == prev_addr) ? run + 1 : 1;
            if (address == 320)   h320   = run;
            if (address == 65856) h65856 = run;
            if (!first_rd_valid) begin
                first_rd_valid = 1'b1;
                first_rd_addr  = address;
            end
            for (int p = 0; p < 64; p++) begin
                if (address < L2B) read_data[p*24 +: 24] = l1_mem[address + p];
                else               read_data[p*24 +: 24] = l2_mem[address - L2B + p];
            end
        end
        prev_re   = read_enable;
        prev_addr = address;
        if (write_enable) begin
            if (wr_count == 0) first_wr = address;
            last_wr = address;
            wr_count++;
            if (address == 143552) hit_143552 = 1'b1;
            if (address >= OUTB)
                for (int p = 0; p < 64; p++) out_mem[address - OUTB + p] = write_data[p*24 +: 24];
        end
        if (merge_done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        wr_count = 0; first_wr = 0; last_wr = 0; done_count = 0; done_cyc = 0;
        h320 = 0; h65856 = 0; hit_143552 = 1'b0; first_rd_valid = 1'b0;
        for (int i = 0; i < 65536; i++) out_mem[i] = '0;
    endtask

    // Start a pass and wait for DONE; returns the edge index at which merge_en was sampled.
    task automatic run_pass(input bit pulse_mid, output int unsigned start_edge);
        bit pulsed = 1'b0;
        @(posedge clk); #1;
        merge_en   = 1'b1;
        start_edge = cyc + 1;
        for (int i = 0; i < 9000 && done_count == 0; i++) begin
            @(posedge clk); #1;
            if (merge_en) merge_en = 1'b0;
            else if (pulse_mid && !pulsed && read_enable && address == 640) begin
                merge_en = 1'b1;
                pulsed   = 1'b1;
            end
        end
        merge_en = 1'b0;
        check("pass_completed", done_count, 1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int unsigned addr;
        logic [23:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[10];
        int unsigned n_edge, bad;

        vecs[0] = '{143360, 24'h000000};
        vecs[1] = '{143679, 24'h0000BB};
        vecs[2] = '{143680, 24'h00AA00};
        vecs[3] = '{143711, 24'h00AA00};
        vecs[4] = '{143712, 24'h0000BB};
        vecs[5] = '{143743, 24'h0000BB};
        vecs[6] = '{144360, 24'h0000BB};
        vecs[7] = '{145360, BOTH_KEY_EXP};
        vecs[8] = '{145361, BOTH_KEY_EXP};
        vecs[9] = '{208895, 24'hFF00FE};

        n_rst = 1'b1; merge_en = 1'b0; key_color = KEY; bg_color = 24'h101010;
        clear_stats();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("idle_addr", address, 0);
            check("idle_strobes", {merge_done, read_enable, write_enable}, 0);
        end
        check("idle_wdata", |write_data, 0);

        // Pass A: layer2 fully transparent, merge_en pulsed mid-pass at chunk 10
        for (int i = 0; i < 65536; i++) begin l1_mem[i] = 24'h112233; l2_mem[i] = KEY; end
        clear_stats();
        run_pass(1'b1, n_edge);
        bad = 0;
        for (int i = 0; i < 65536; i++) if (out_mem[i] !== 24'h112233) bad++;
        check("passA_bad_words", bad, 0);
        check("passA_first_wr", first_wr, 143360);
        check("passA_last_wr", last_wr, 208832);
        check("passA_wr_count", wr_count, NC);
        check("passA_done_count", done_count, 1);
        // DONE occupies the cycle following edge n_edge + 8*NC
        check("passA_done_cycle", done_cyc, n_edge + 8 * NC);

        // Reset during RD2_B of chunk 3
        clear_stats();
        @(posedge clk); #1 merge_en = 1'b1;
        @(posedge clk); #1 merge_en = 1'b0;
        for (int i = 0; i < 200 && !(read_enable && address == L2B + 192); i++) begin
            @(posedge clk); #1;
        end
        check("rst_reached_chunk3", address, L2B + 192);
        @(posedge clk); #1 n_rst = 1'b1;
        @(posedge clk); #1 n_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (read_enable || write_enable || merge_done || address != 0) bad++;
        end
        check("rst_quiet_after", bad, 0);
        check("rst_no_wr_143552", hit_143552, 0);
        check("rst_wr_count", wr_count, 3);
        first_rd_valid = 1'b0;
        merge_en = 1'b1;
        @(posedge clk); #1 merge_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("restart_rd_valid", first_rd_valid, 1);
        check("restart_rd_addr", first_rd_addr, 0);
        n_rst = 1'b1;
        @(posedge clk); #1 n_rst = 1'b0;

        // Pass B: mixed chunk 5 plus boundary pixels
        for (int i = 0; i < 65536; i++) begin l1_mem[i] = 24'h0000BB; l2_mem[i] = KEY; end
        for (int i = 320; i < 352; i++) l2_mem[i] = 24'h00AA00;
        l2_mem[0]     = 24'h000000;
        l2_mem[65535] = 24'hFF00FE;
        l1_mem[2000]  = KEY;
        l1_mem[2001]  = KEY;
        clear_stats();
        run_pass(1'b0, n_edge);
        for (int i = 0; i < 10; i++)
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), out_mem[vecs[i].addr - OUTB], vecs[i].exp);
        bad = 0;
        for (int i = 143680; i < 143744; i++)
            if (out_mem[i - OUTB] !== ((i < 143712) ? 24'h00AA00 : 24'h0000BB)) bad++;
        check("chunk5_bad_words", bad, 0);
        check("hold_rd_320", h320, 2);
        check("hold_rd_65856", h65856, 2);
        check("passB_done_cycle", done_cyc, n_edge + 8 * NC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
